// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for a 4-digit common-anode 7-segment
// display showing MM:SS, with per-digit blink, leading-zero blanking and
// a blinking colon on the slot-2 decimal point.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   d0..d3          BCD digits (d0 = seconds units ... d3 = minutes tens)
//   blank_lz        blank slot 3 when the latched d3 is zero
//   tick            one-cycle 1 Hz pulse, toggles the blink phase
//   blink_mask      bit k set makes slot k blink with the phase
//   seg_n           {g,f,e,d,c,b,a}, active-low
//   dp_n            decimal point / colon, active-low
//   an_n            one-hot active-low anode enables, bit k = slot k
//   frame           one-cycle pulse when the digit snapshot loads
//
// Parameters:
//   SCAN_DIV        clk cycles per digit slot (4..65535)
//   GUARD           anode-off cycles at the start of each slot
//                   (1..SCAN_DIV-2), hides ghosting while segments settle
module seg7_scan #(
    parameter int SCAN_DIV = 5000,
    parameter int GUARD    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic       blank_lz,
    input  logic       tick,
    input  logic [3:0] blink_mask,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [3:0] an_n,
    output logic       frame
);

    localparam logic [15:0] PC_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] PC_GUARD = 16'(GUARD);

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [15:0] pcnt;
    logic [1:0]  slot;
    logic        phase;
    logic [3:0]  s0, s1, s2, s3;

    logic pwrap;
    logic fwrap;

    assign pwrap = (pcnt == PC_LAST);
    assign fwrap = pwrap && (slot == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt  <= '0;
            slot  <= '0;
            phase <= 1'b0;
            s0    <= '0;
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
        end else begin
            if (pwrap) begin
                pcnt <= '0;
                slot <= slot + 2'd1;
            end else begin
                pcnt <= pcnt + 16'd1;
            end
            // Snapshot only at the frame boundary so a digit change
            // never shows up half-way through a frame.
            if (fwrap) begin
                s0 <= d0;
                s1 <= d1;
                s2 <= d2;
                s3 <= d3;
            end
            phase <= phase ^ tick;
        end
    end

    // ------------------------------------------------------------------
    // Segment decode
    // ------------------------------------------------------------------
    function automatic logic [6:0] bcd_seg(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'd0:    r = 7'h40;
            4'd1:    r = 7'h79;
            4'd2:    r = 7'h24;
            4'd3:    r = 7'h30;
            4'd4:    r = 7'h19;
            4'd5:    r = 7'h12;
            4'd6:    r = 7'h02;
            4'd7:    r = 7'h78;
            4'd8:    r = 7'h00;
            4'd9:    r = 7'h10;
            default: r = SEG_DASH;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Next-output logic, computed from the current state and
    // registered below (one cycle of latency to the pins).
    // ------------------------------------------------------------------
    logic [3:0] cur;
    logic       guard;
    logic       blink;
    logic       lz;
    logic [3:0] an_nxt;
    logic [6:0] seg_nxt;
    logic       dp_nxt;

    always_comb begin
        cur = s0;
        unique case (slot)
            2'd0: cur = s0;
            2'd1: cur = s1;
            2'd2: cur = s2;
            2'd3: cur = s3;
        endcase
    end

    assign guard = (pcnt < PC_GUARD);
    assign blink = blink_mask[slot] && phase;
    assign lz    = blank_lz && (slot == 2'd3) && (s3 == 4'd0);

    always_comb begin
        an_nxt  = 4'hF;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        if (!guard) begin
            an_nxt = ~(4'b0001 << slot);
            dp_nxt = !((slot == 2'd2) && !phase);
            if (blink || lz) begin
                seg_nxt = SEG_OFF;
            end else begin
                seg_nxt = bcd_seg(cur);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_n  <= 4'hF;
            seg_n <= SEG_OFF;
            dp_n  <= 1'b1;
            frame <= 1'b0;
        end else begin
            an_n  <= an_nxt;
            seg_n <= seg_nxt;
            dp_n  <= dp_nxt;
            frame <= fwrap;
        end
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 5000: clk cycles per digit slot, legal range 4..65535.
REQ-002 SHALL have parameter GUARD, default 16: anode-off cycles at the start of each slot, legal range 1..SCAN_DIV-2.
REQ-003 SHALL have port clk, input, 1 bit: clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port d0, input, 4 bits: BCD seconds units, shown in slot 0.
REQ-006 SHALL have port d1, input, 4 bits: BCD seconds tens, shown in slot 1.
REQ-007 SHALL have port d2, input, 4 bits: BCD minutes units, shown in slot 2.
REQ-008 SHALL have port d3, input, 4 bits: BCD minutes tens, shown in slot 3.
REQ-009 SHALL have port blank_lz, input, 1 bit: blank slot 3 when the latched d3 is 0.
REQ-010 SHALL have port tick, input, 1 bit: one-cycle 1 Hz pulse that drives the blink phase.
REQ-011 SHALL have port blink_mask, input, 4 bits: bit k set makes slot k blink.
REQ-012 SHALL have port seg_n, output, 7 bits: {g,f,e,d,c,b,a}, active-low.
REQ-013 SHALL have port dp_n, output, 1 bit: decimal point / colon, active-low.
REQ-014 SHALL have port an_n, output, 4 bits: digit anodes, one-hot active-low, bit k drives slot k.
REQ-015 SHALL have port frame, output, 1 bit: one-cycle pulse when the digit latch loads.

Function
REQ-016 SHALL keep a prescaler pcnt that counts 0..SCAN_DIV-1 and wraps to 0.
REQ-017 SHALL advance the 2-bit slot 0->1->2->3->0 in the cycle pcnt wraps.
REQ-018 SHALL load d0..d3 into a snapshot latch in the cycle slot wraps 3->0, and frame SHALL pulse that same cycle; inputs SHALL have no effect on pins between loads (no tearing).
REQ-019 SHALL, while pcnt<GUARD, drive an_n=4'hF, seg_n=7'h7F and dp_n=1; otherwise an_n SHALL be low on bit slot only.
REQ-020 SHALL register every output, so pins reflect the pcnt/slot state of the previous cycle (1-cycle latency).
REQ-021 SHALL decode 0-9 to seg_n as: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-022 SHALL decode codes A-F to 3F (dash, g only) as a visible error indication.
REQ-023 SHALL toggle a phase bit on each tick, with phase reset value 0.
REQ-024 SHALL blank a slot (seg_n=7F) when blink_mask[slot]=1 and phase=1; anode enabling SHALL be unchanged.
REQ-025 SHALL blank slot 3 when blank_lz=1 and the latched d3=0.
REQ-026 SHALL set precedence: guard > blink > leading-zero > decode.
REQ-027 SHALL drive dp_n=0 only in slot 2 outside guard with phase=0 (colon blinking at 0.5 Hz duty); dp_n SHALL be unaffected by blink_mask.
REQ-028 SHALL let a tick coincident with a slot or frame wrap take effect on the next cycle's outputs, like any other state.
REQ-029 SHALL sample blink_mask and blank_lz live, not latched.

Reset
REQ-030 SHALL, with rst=1, clear pcnt, slot, phase and the snapshot to 0, and drive an_n=F, seg_n=7F, dp_n=1, frame=0 on the next edge.
REQ-031 SHALL restart from slot 0 / pcnt 0 when rst is asserted mid-slot, with no partial frame pulse.
REQ-032 SHALL display 0000 in the first frame after reset, until the first 3->0 wrap loads live digits.

Verification (SCAN_DIV=8, GUARD=2)
REQ-033 SHALL cover scan order: rst released, d=5,9,3,1 held -> an_n sequence E,D,B,7 every 8 cycles with F in the first 2 cycles of each slot; after the first frame pulse, seg_n 12,10,30,79.
REQ-034 SHALL cover latching: change d0 mid-frame from 5 to 6 -> seg_n for slot 0 stays 12 until after the next frame pulse, then 02.
REQ-035 SHALL cover blink: blink_mask=0011, one tick -> slots 0,1 show seg_n=7F with an_n still cycling; second tick -> digits restored.
REQ-036 SHALL cover leading zero and error decode: d3=0 with blank_lz=1 -> slot 3 seg_n=7F; blank_lz=0 -> 40; d2=C -> slot 2 seg_n=3F.
REQ-037 SHALL cover the colon: phase=0 -> dp_n=0 only during the non-guard cycles of slot 2; after one tick -> dp_n constantly 1.
REQ-038 SHALL cover mid-slot reset: rst pulsed at pcnt=5 of slot 2 -> next edge an_n=F, and slot 0 restarts with no frame pulse before the first 3->0 wrap.
